// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO push port among nreq producers.
// Each grant is capped at `burst` accepted words; one idle cycle separates grants.
module fifo_push_arbiter #(
    parameter int busw  = 32,
    parameter int nreq  = 4,
    parameter int burst = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [nreq-1:0]          req,
    input  logic [nreq*busw-1:0]     din,
    output logic [nreq-1:0]          ack,
    input  logic                     fifo_full,
    output logic                     fifo_push,
    output logic [busw-1:0]          fifo_datain,
    output logic [$clog2(nreq)-1:0]  gnt_id,
    output logic                     busy,
    output logic [31:0]              pushed_cnt
);

    localparam int idw = $clog2(nreq);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state;
    logic [idw-1:0]   owner;
    logic [idw-1:0]   last_gnt;
    logic [7:0]       beat;
    logic [idw-1:0]   next_owner;
    logic [idw-1:0]   cand;
    logic             found;

    // Search starts just after the previous owner so every requester gets a turn.
    always_comb begin
        next_owner = '0;
        cand       = '0;
        found      = 1'b0;
        for (int i = 1; i <= nreq; i++) begin
            cand = idw'((int'(last_gnt) + i) % nreq);
            if (!found && req[cand]) begin
                found      = 1'b1;
                next_owner = cand;
            end
        end
    end

    always_comb begin
        fifo_push   = 1'b0;
        fifo_datain = '0;
        ack         = '0;
        if (state == GRANT) begin
            fifo_push   = req[owner] & ~fifo_full;
            fifo_datain = din[int'(owner)*busw +: busw];
            ack[owner]  = req[owner] & ~fifo_full;
        end
    end

    assign busy   = (state == GRANT);
    assign gnt_id = owner;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= '0;
            beat       <= '0;
            last_gnt   <= idw'(nreq - 1);
            pushed_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        owner <= next_owner;
                        beat  <= '0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (fifo_push) begin
                        beat       <= beat + 8'd1;
                        pushed_cnt <= pushed_cnt + 32'd1;
                        if (beat + 8'd1 == 8'(burst)) begin
                            state    <= IDLE;
                            last_gnt <= owner;
                        end
                    // A dropped request withdraws the word; full alone never releases.
                    end else if (!req[owner]) begin
                        state    <= IDLE;
                        last_gnt <= owner;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Randomised self-checking bench for fifo_push_arbiter with a behavioural
// arbitration model and a 32-entry FIFO model on the push side.
module tb_fifo_push_arbiter;

    localparam int BW    = 32;
    localparam int NR    = 4;
    localparam int BU    = 4;
    localparam int DEPTH = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR*BW-1:0]  din;
    logic [NR-1:0]     ack;
    logic              fifo_full;
    logic              fifo_push;
    logic [BW-1:0]     fifo_datain;
    logic [1:0]        gnt_id;
    logic              busy;
    logic [31:0]       pushed_cnt;

    always #5 clk = ~clk;

    fifo_push_arbiter #(.busw(BW), .nreq(NR), .burst(BU)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .din(din),
        .ack(ack),
        .fifo_full(fifo_full),
        .fifo_push(fifo_push),
        .fifo_datain(fifo_datain),
        .gnt_id(gnt_id),
        .busy(busy),
        .pushed_cnt(pushed_cnt)
    );

    int total = 0;
    int bad   = 0;

    int           words_left[NR];
    logic [BW-1:0] pword[NR];
    logic [BW-1:0] fifo_q[$];
    logic [BW-1:0] sb[$];
    bit           rand_mode = 0;
    bit           hold_full = 0;
    int           pop_prob  = 100;
    int           req_prob  = 0;
    int           wd_prob   = 0;
    int           full_prob = 0;
    logic [NR-1:0] dut_ack_seen;

    // Model: owner of -1 means nobody holds the port.
    int          m_owner = -1;
    int          m_last  = NR - 1;
    int          m_beat  = 0;
    logic [31:0] m_cnt   = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = NR - 1;
        m_beat  = 0;
        m_cnt   = '0;
    endtask

    // One clock cycle: drive producers, compare against the model, advance everything.
    task automatic step();
        bit            e_busy, e_push, taken;
        logic [NR-1:0] e_ack;
        logic [BW-1:0] d;
        for (int i = 0; i < NR; i++) begin
            if (rand_mode) begin
                if (words_left[i] == 0 && $urandom_range(99) < req_prob) begin
                    words_left[i] = $urandom_range(1, 12);
                    pword[i]      = $urandom;
                end else if (words_left[i] > 0 && $urandom_range(99) < wd_prob) begin
                    words_left[i] = 0;
                end
            end
            req[i]            = (words_left[i] > 0);
            din[i*BW +: BW]   = pword[i];
        end
        if (rand_mode) hold_full = ($urandom_range(99) < full_prob);
        fifo_full = (fifo_q.size() >= DEPTH) || hold_full;
        #2;
        e_busy = (m_owner >= 0);
        e_push = e_busy && req[m_owner] && !fifo_full;
        e_ack  = '0;
        if (e_push) e_ack[m_owner] = 1'b1;
        check("busy", busy, e_busy);
        check("fifo_push", fifo_push, e_push);
        check("ack", ack, e_ack);
        check("pushed_cnt", pushed_cnt, m_cnt);
        if (e_busy) begin
            check("gnt_id", gnt_id, m_owner);
            check("fifo_datain", fifo_datain, pword[m_owner]);
        end
        dut_ack_seen = ack;
        if ($urandom_range(99) < pop_prob && fifo_q.size() > 0) begin
            d = fifo_q.pop_front();
            if (sb.size() > 0) check("fifo_order", d, sb.pop_front());
        end
        if (fifo_push && fifo_q.size() < DEPTH) fifo_q.push_back(fifo_datain);
        if (e_push) sb.push_back(pword[m_owner]);
        for (int i = 0; i < NR; i++) begin
            if (e_ack[i]) begin
                words_left[i]--;
                pword[i] = $urandom;
            end
        end
        if (!e_busy) begin
            taken = 0;
            for (int k = 1; k <= NR; k++) begin
                if (!taken && req[(m_last + k) % NR]) begin
                    taken   = 1;
                    m_owner = (m_last + k) % NR;
                    m_beat  = 0;
                end
            end
        end else if (e_push) begin
            m_cnt++;
            m_beat++;
            if (m_beat == BU) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end else if (!req[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_left(input int who, input int target, input int budget, input string name);
        for (int n = 0; n < budget && words_left[who] > target; n++) step();
        check(name, words_left[who] <= target, 1);
    endtask

    task automatic stop_all(input int cycles);
        for (int i = 0; i < NR; i++) words_left[i] = 0;
        for (int n = 0; n < cycles; n++) step();
    endtask

    initial begin
        logic [31:0] cnt0;
        logic [31:0] pat;
        int          npat;
        bit          started;
        bit          prev_busy;
        logic [1:0]  seq[$];

        rst       = 1'b0;
        fifo_full = 1'b0;
        for (int i = 0; i < NR; i++) begin
            words_left[i] = 1000;
            pword[i]      = $urandom;
            req[i]        = 1'b1;
            din[i*BW +: BW] = pword[i];
        end
        #12;
        check("rst_busy", busy, 0);
        check("rst_push", fifo_push, 0);
        check("rst_ack", ack, 0);
        check("rst_cnt", pushed_cnt, 0);
        check("rst_gnt", gnt_id, 0);
        check("rst_data", fifo_datain, 0);
        #5;
        rst = 1'b1;

        // All four requesting from reset: grant order 0,1,2,3,0 with one idle cycle between.
        for (int k = 0; k < 22; k++) begin
            step();
            if (k + 1 == 1) begin
                check("p1_c1_busy", busy, 1);
                check("p1_c1_gnt", gnt_id, 0);
            end
            if (k + 1 == 5) begin
                check("p1_c5_cnt", pushed_cnt, 4);
                check("p1_c5_busy", busy, 0);
            end
            if (k + 1 == 6)  check("p1_c6_gnt", gnt_id, 1);
            if (k + 1 == 11) check("p1_c11_gnt", gnt_id, 2);
            if (k + 1 == 16) check("p1_c16_gnt", gnt_id, 3);
            if (k + 1 == 21) check("p1_c21_gnt", gnt_id, 0);
        end
        stop_all(4);

        // Lone requester 2 with 10 words: bursts of 4,4,2.
        cnt0          = pushed_cnt;
        words_left[2] = 10;
        started       = 0;
        pat           = '0;
        npat          = 0;
        for (int n = 0; n < 40 && words_left[2] > 0; n++) begin
            step();
            if (dut_ack_seen[2]) started = 1;
            if (started) begin
                pat = {pat[30:0], dut_ack_seen[2]};
                npat++;
            end
        end
        check("p2_pattern", pat, 32'hF7B);
        check("p2_len", npat, 12);
        check("p2_cnt", pushed_cnt - cnt0, 10);
        stop_all(3);

        // Owner 3 withdraws after one word; the next grant wraps to 0.
        words_left[3] = 1;
        words_left[0] = 2;
        prev_busy     = 0;
        for (int n = 0; n < 15; n++) begin
            step();
            if (busy && !prev_busy) seq.push_back(gnt_id);
            prev_busy = busy;
        end
        check("p4_ngrants", seq.size() >= 2, 1);
        if (seq.size() >= 2) begin
            check("p4_first", seq[0], 3);
            check("p4_second", seq[1], 0);
        end
        stop_all(3);

        // FIFO full for five cycles in the middle of requester 1's burst.
        cnt0          = pushed_cnt;
        words_left[1] = 4;
        run_until_left(1, 2, 20, "p3_first_two");
        hold_full = 1;
        for (int n = 0; n < 5; n++) begin
            step();
            check("p3_full_busy", busy, 1);
            check("p3_full_gnt", gnt_id, 1);
        end
        hold_full = 0;
        run_until_left(1, 0, 20, "p3_rest");
        check("p3_cnt", pushed_cnt - cnt0, 4);
        stop_all(3);

        // Asynchronous reset two words into requester 1's burst.
        words_left[1] = 4;
        run_until_left(1, 2, 20, "p5_two");
        #2;
        rst = 1'b0;
        #1;
        check("p5_push", fifo_push, 0);
        check("p5_ack", ack, 0);
        check("p5_busy", busy, 0);
        check("p5_cnt", pushed_cnt, 0);
        model_reset();
        words_left[0] = 0;
        words_left[2] = 1;
        words_left[3] = 0;
        #3;
        rst = 1'b1;
        step();
        check("p5_regrant_busy", busy, 1);
        check("p5_regrant_gnt", gnt_id, 1);
        stop_all(20);

        // Fill the FIFO with no pops: exactly DEPTH words accepted.
        pop_prob = 0;
        cnt0     = pushed_cnt;
        for (int i = 0; i < NR; i++) words_left[i] = 20;
        for (int n = 0; n < 80; n++) step();
        check("p6_fifo_level", fifo_q.size(), DEPTH);
        check("p6_cnt", pushed_cnt - cnt0, DEPTH);

        // Randomised traffic with varying pull rate, back-pressure and withdrawals.
        rand_mode = 1;
        for (int seg = 0; seg < 15; seg++) begin
            pop_prob  = $urandom_range(10, 100);
            req_prob  = $urandom_range(5, 60);
            wd_prob   = $urandom_range(0, 3);
            full_prob = $urandom_range(0, 10);
            for (int n = 0; n < 200; n++) step();
        end
        rand_mode = 0;
        hold_full = 0;
        pop_prob  = 100;
        stop_all(60);
        check("end_fifo_drained", fifo_q.size(), 0);
        check("end_sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
